// File: rtl/score_bcd_counter_if.sv
// rtl/score_bcd_counter_if.sv - event inputs and frame-latched display outputs of the score counter
//
// Signals:
//   inc, dec, clr, frame_tick    : game-logic events and the vertical-blank pulse (master -> slave)
//   digit0..digit3               : displayed BCD digits, digit0 = ones (slave -> master)
//   ovf                          : sticky saturation flag (slave -> master)
//   blank                        : per-digit leading-zero blank mask (slave -> master)
interface score_bcd_counter_if;
    logic       inc;
    logic       dec;
    logic       clr;
    logic       frame_tick;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       ovf;
    logic [3:0] blank;

    modport master (
        output inc, dec, clr, frame_tick,
        input  digit0, digit1, digit2, digit3, ovf, blank
    );

    modport slave (
        input  inc, dec, clr, frame_tick,
        output digit0, digit1, digit2, digit3, ovf, blank
    );
endinterface

// File: rtl/score_bcd_counter.sv
// rtl/score_bcd_counter.sv - four-digit saturating BCD score counter with frame-latched display copy
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset; overrides every other input
//   bus    : score_bcd_counter_if.slave
//            inc/dec    level events, +1/-1 per clock (both high = no change)
//            clr        clears the working count and ovf; display untouched
//            frame_tick latches the pre-edge working count into the display copy
//            digit0..3  display copy nibbles, ovf live sticky flag, blank mask
// Parameter:
//   MAX_SCORE : decimal saturation ceiling, 0..9999
// Optional feature macro:
//   SCORE_LEADING_ZERO_BLANK_EN : registered leading-zero blank mask; when undefined blank is 0
module score_bcd_counter #(
    parameter int MAX_SCORE = 9999
) (
    input  logic                clk,
    input  logic                reset,
    score_bcd_counter_if.slave  bus
);

    localparam logic [15:0] MAX_BCD = {4'(MAX_SCORE / 1000 % 10),
                                       4'(MAX_SCORE / 100 % 10),
                                       4'(MAX_SCORE / 10 % 10),
                                       4'(MAX_SCORE % 10)};

    logic [15:0] cnt;
    logic [15:0] disp;
    logic        ovf;
    logic [15:0] cnt_inc;
    logic [15:0] cnt_dec;
    logic        carry;
    logic        borrow;

    // Full BCD ripple in one cycle: a nibble at 9 wraps to 0 and passes the carry on.
    // The top-level carry out is never used because inc is blocked at MAX_BCD.
    always_comb begin
        cnt_inc = cnt;
        carry   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (carry) begin
                if (cnt[4*k +: 4] == 4'd9) begin
                    cnt_inc[4*k +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*k +: 4] = cnt[4*k +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // BCD borrow: a nibble at 0 wraps to 9; never applied when cnt is zero.
    always_comb begin
        cnt_dec = cnt;
        borrow  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (borrow) begin
                if (cnt[4*k +: 4] == 4'd0) begin
                    cnt_dec[4*k +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*k +: 4] = cnt[4*k +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 16'h0000;
            disp <= 16'h0000;
            ovf  <= 1'b0;
        end else begin
            // disp samples cnt as held before this edge, so same-edge count updates miss it.
            if (bus.frame_tick) begin
                disp <= cnt;
            end
            if (bus.clr) begin
                cnt <= 16'h0000;
                ovf <= 1'b0;
            end else if (bus.inc && !bus.dec) begin
                if (cnt == MAX_BCD) begin
                    ovf <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                end
            end else if (bus.dec && !bus.inc) begin
                if (cnt != 16'h0000) begin
                    cnt <= cnt_dec;
                end
            end
        end
    end

    assign bus.digit0 = disp[3:0];
    assign bus.digit1 = disp[7:4];
    assign bus.digit2 = disp[11:8];
    assign bus.digit3 = disp[15:12];
    assign bus.ovf    = ovf;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic [3:0] blank;
    logic [3:0] blank_next;

    // Mask follows the value being latched into disp; the ones digit is never blanked.
    always_comb begin
        blank_next    = 4'b0000;
        blank_next[3] = (cnt[15:12] == 4'd0);
        blank_next[2] = blank_next[3] & (cnt[11:8] == 4'd0);
        blank_next[1] = blank_next[2] & (cnt[7:4] == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank <= 4'b1110;
        end else if (bus.frame_tick) begin
            blank <= blank_next;
        end
    end

    assign bus.blank = blank;
`else
    assign bus.blank = 4'b0000;
`endif

endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
- Four-digit BCD score counter whose frame-latched digit outputs drive the value inputs of four glyph-rendering digit stages in the VGA text/score overlay.
- Counts inc/dec events from game logic.
- Display copy updates only on the frame tick (start of vertical blank) so a digit never changes mid-frame (no tearing).

Parameters:
- MAX_SCORE, 9999: decimal saturation ceiling for the count. Legal range 0..9999. Converted to a BCD constant at elaboration.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- inc  input  1  level; +1 per clock while high
- dec  input  1  level; -1 per clock while high
- clr  input  1  synchronous clear of the working count
- frame_tick  input  1  one-cycle pulse at vertical-blank start; latches the display copy
- digit0  output  4  displayed ones digit (BCD)
- digit1  output  4  displayed tens digit
- digit2  output  4  displayed hundreds digit
- digit3  output  4  displayed thousands digit
- ovf  output  1  sticky: an inc was attempted at MAX_SCORE
- blank  output  4  per-digit leading-zero blank mask (see Optional Feature)

Behaviour:
- State:
  - working register cnt[15:0]: four BCD nibbles, nibble 0 = ones.
  - display register disp[15:0].
  - ovf flag.
  - All outputs registered.
- Reset (reset=1 at a clock edge): cnt=0, disp=0, ovf=0, blank=4'b1110 when the macro is defined, else 0. Reset overrides all other inputs.
- Priority per edge: reset > clr > (inc, dec).
- clr=1:
  - cnt<=0, ovf<=0.
  - inc/dec ignored that cycle.
  - disp is not touched; it picks up the zero at the next frame_tick.
- Increment (inc=1, dec=0):
  - If cnt == BCD(MAX_SCORE): cnt holds and ovf<=1.
  - Otherwise cnt <= cnt+1 with full BCD ripple in one cycle: a nibble at 9 wraps to 0 and carries to the next nibble.
- Decrement (inc=0, dec=1):
  - If cnt == 0: cnt holds. No flag.
  - Otherwise cnt <= cnt-1 with BCD borrow: a nibble at 0 wraps to 9 and borrows from the next nibble.
- inc=1 and dec=1 together: cnt unchanged, ovf unchanged.
- Nibbles never leave 0..9. No input path can load a non-BCD value.
- Count latency: cnt reflects an inc/dec sampled at edge N immediately after edge N.
- Display latch:
  - On an edge with frame_tick=1 (and reset=0): disp <= cnt as held before that edge. Updates to cnt on the same edge are not included.
  - Without frame_tick, disp holds indefinitely.
  - digitK = disp nibble K.
- Simultaneous events:
  - frame_tick with clr: disp gets the pre-clear value; cnt clears.
  - frame_tick with inc: disp gets the old value; cnt increments.
- ovf:
  - Set only by a saturating inc.
  - Cleared only by clr or reset.
  - Not latched through frame_tick; it is live.
- Reset mid-count or mid-frame: everything returns to reset values on that edge. The next frame_tick latches 0000.

Optional Feature:
- Macro: SCORE_LEADING_ZERO_BLANK_EN
- Defined:
  - blank is registered and updated on the same edge as disp, computed from the value being latched.
  - blank[3] = (d3==0)
  - blank[2] = blank[3] & (d2==0)
  - blank[1] = blank[2] & (d1==0)
  - blank[0] = 0 always; the ones digit always shows.
  - Reset value 4'b1110.
  - Downstream gates each digit stage's pixel-on output with ~blank[K].
- Not defined: blank is constant 4'b0000. No extra registers.

Test Plan:
- Reset, then frame_tick, then 12 cycles of inc=1, then frame_tick -> digits 3..0 read 0,0,1,2; ovf=0; digits unchanged between the ticks.
- Preload by inc to 0099, then one inc -> cnt=0100 on the next edge (double carry). Preload 1000, then one dec -> 0999 (triple borrow). Latch each with frame_tick and check digits.
- MAX_SCORE=9999 at 9998, inc held for 3 cycles -> cnt 9999 after the first edge, then holds; ovf=1 from the second inc edge. clr -> cnt=0, ovf=0. Display still shows 9999 until the next frame_tick.
- cnt=0005 with inc=dec=1 for 4 cycles -> stays 0005. dec at 0000 -> stays 0000, ovf=0.
- frame_tick on the same edge as inc at cnt=0041 -> disp=0041, cnt=0042; the next frame_tick shows 0042. Reset asserted mid-sequence -> all digits 0 and ovf=0 on the following cycle.
- With SCORE_LEADING_ZERO_BLANK_EN and latched value 0007 -> blank=1110. Value 0100 -> blank=1000. Value 0000 -> blank=1110. Without the macro -> blank=0000 for all three.
